pipe_hazard_ctrl: RTL and testbench

Central stall/flush/forward controller for the 5-stage RISC-V pipeline.
- Drives the enable and flush inputs of the PC and of pipeline registers IR1 (IF/ID), IR2 (ID/EX), IR3 (EX/MEM) and IR4 (MEM/WB).
- Generates the EX-stage forwarding selects.
- Sequences the data-memory request/ready handshake for the MEM stage, including a timeout error.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl_fwd.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding-select codes and a register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam int WAIT_W = 16;

  // x0 is hard-wired to zero, so it can never create a dependency.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. master = controller,
// slave = pipeline datapath and data memory.
interface pipe_hazard_ctrl_if;
  logic [4:0] rs1_IR1, rs2_IR1;
  logic [4:0] rs1_IR2, rs2_IR2;
  logic [4:0] instb_IR2;
  logic       MemRead_IR2;
  logic [4:0] instb_IR3;
  logic       RegWrite_IR3, MemRead_IR3, MemWrite_IR3, Branch_IR3, zero_IR3;
  logic [4:0] instb_IR4;
  logic       RegWrite_IR4;
  logic       dmem_ready;
  logic       dmem_req;
  logic       pc_en, IR1_en, IR2_en, IR3_en, IR4_en;
  logic       IR1_flush, IR2_flush, IR3_flush, IR4_flush;
  logic       pc_sel;
  logic [1:0] forwardA, forwardB;
  logic       mem_err;

  modport master (
    input  rs1_IR1, rs2_IR1, rs1_IR2, rs2_IR2, instb_IR2, MemRead_IR2,
           instb_IR3, RegWrite_IR3, MemRead_IR3, MemWrite_IR3, Branch_IR3, zero_IR3,
           instb_IR4, RegWrite_IR4, dmem_ready,
    output dmem_req, pc_en, IR1_en, IR2_en, IR3_en, IR4_en,
           IR1_flush, IR2_flush, IR3_flush, IR4_flush, pc_sel,
           forwardA, forwardB, mem_err
  );

  modport slave (
    output rs1_IR1, rs2_IR1, rs1_IR2, rs2_IR2, instb_IR2, MemRead_IR2,
           instb_IR3, RegWrite_IR3, MemRead_IR3, MemWrite_IR3, Branch_IR3, zero_IR3,
           instb_IR4, RegWrite_IR4, dmem_ready,
    input  dmem_req, pc_en, IR1_en, IR2_en, IR3_en, IR4_en,
           IR1_flush, IR2_flush, IR3_flush, IR4_flush, pc_sel,
           forwardA, forwardB, mem_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX-stage operand forwarding: purely combinational, the MEM-stage result
// wins over the writeback result when both match.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_IR2,
  input  logic [4:0] rs2_IR2,
  input  logic [4:0] instb_IR3,
  input  logic       RegWrite_IR3,
  input  logic [4:0] instb_IR4,
  input  logic       RegWrite_IR4,
  output logic [1:0] forwardA,
  output logic [1:0] forwardB
);

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] dst3, input logic we3,
                                         input logic [4:0] dst4, input logic we4);
    if (we3 && reg_match(dst3, src)) return FWD_MEM;
    if (we4 && reg_match(dst4, src)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign forwardA = fwd_sel(rs1_IR2, instb_IR3, RegWrite_IR3, instb_IR4, RegWrite_IR4);
  assign forwardB = fwd_sel(rs2_IR2, instb_IR3, RegWrite_IR3, instb_IR4, RegWrite_IR4);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with MEM-stage
// handshake and timeout. Optional performance counters under PIPE_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                reset_n,
  pipe_hazard_ctrl_if.master bus
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_events
`endif
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;
  logic              mem_op, br_taken, load_use, hold;

  assign mem_op   = bus.MemRead_IR3 | bus.MemWrite_IR3;
  assign br_taken = bus.Branch_IR3 & bus.zero_IR3;
  assign load_use = bus.MemRead_IR2 &
                    (reg_match(bus.instb_IR2, bus.rs1_IR1) | reg_match(bus.instb_IR2, bus.rs2_IR1));

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (mem_op && !bus.dmem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (bus.dmem_ready)            state_nxt = RUN;
                else if (wait_cnt == TIMEOUT_CNT) state_nxt = ERROR;
      ERROR:    state_nxt = ERROR;
      default:  state_nxt = RUN;
    endcase
  end

  // Wait counter saturates at all-ones so a huge MEM_TIMEOUT can never wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state == RUN && state_nxt == MEM_WAIT)
        wait_cnt <= WAIT_W'(1);
      else if (state == MEM_WAIT && wait_cnt != '1)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (state_nxt == ERROR)
        mem_err_q <= 1'b1;
    end
  end

  assign bus.mem_err = mem_err_q;

  always_comb begin
    bus.pc_en     = 1'b1;
    bus.IR1_en    = 1'b1;
    bus.IR2_en    = 1'b1;
    bus.IR3_en    = 1'b1;
    bus.IR4_en    = 1'b1;
    bus.IR1_flush = 1'b0;
    bus.IR2_flush = 1'b0;
    bus.IR3_flush = 1'b0;
    bus.IR4_flush = 1'b0;
    bus.pc_sel    = 1'b0;
    bus.dmem_req  = mem_op;
    hold          = 1'b0;
    unique case (state)
      RUN:      hold = mem_op & ~bus.dmem_ready;
      MEM_WAIT: begin
        hold         = ~bus.dmem_ready;
        bus.dmem_req = 1'b1;
      end
      default:  hold = 1'b0;
    endcase

    if (state == ERROR) begin
      bus.pc_en    = 1'b0;
      bus.IR1_en   = 1'b0;
      bus.IR2_en   = 1'b0;
      bus.IR3_en   = 1'b0;
      bus.IR4_en   = 1'b0;
      bus.dmem_req = 1'b0;
    end else if (hold) begin
      // Freeze the front of the pipe; WB drains and receives a bubble.
      bus.pc_en     = 1'b0;
      bus.IR1_en    = 1'b0;
      bus.IR2_en    = 1'b0;
      bus.IR3_en    = 1'b0;
      bus.IR4_flush = 1'b1;
    end else if (br_taken) begin
      bus.pc_sel    = 1'b1;
      bus.IR1_flush = 1'b1;
      bus.IR2_flush = 1'b1;
      bus.IR3_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en     = 1'b0;
      bus.IR1_en    = 1'b0;
      bus.IR2_flush = 1'b1;
    end
  end

  pipe_fwd_unit u_fwd (
    .rs1_IR2      (bus.rs1_IR2),
    .rs2_IR2      (bus.rs2_IR2),
    .instb_IR3    (bus.instb_IR3),
    .RegWrite_IR3 (bus.RegWrite_IR3),
    .instb_IR4    (bus.instb_IR4),
    .RegWrite_IR4 (bus.RegWrite_IR4),
    .forwardA     (bus.forwardA),
    .forwardB     (bus.forwardB)
  );

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!bus.pc_en && state != ERROR) stall_cycles <= stall_cycles + CNT_W'(1);
      if (bus.pc_sel)                   flush_events <= flush_events + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: RUN-state vector table plus
// multi-cycle sequences; counter checks are compiled in with PIPE_PERF_EN.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  typedef struct packed {
    logic [4:0] rs1_1, rs2_1, rs1_2, rs2_2, instb2;
    logic       memread2;
    logic [4:0] instb3;
    logic       regwrite3, memread3, memwrite3, branch3, zero3;
    logic [4:0] instb4;
    logic       regwrite4, ready;
  } in_t;

  // en = {pc, IR1, IR2, IR3, IR4}, fl = {IR1, IR2, IR3, IR4}
  typedef struct packed {
    logic [4:0] en;
    logic [3:0] fl;
    logic       sel, req, err;
    logic [1:0] fa, fb;
  } out_t;

  typedef struct { string name; in_t in; out_t exp; } vec_t;
  typedef struct { string name; out_t exp; } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic out_t mk(input logic [4:0] en, input logic [3:0] fl, input logic sel,
                              input logic req, input logic err, input logic [1:0] fa,
                              input logic [1:0] fb);
    return {en, fl, sel, req, err, fa, fb};
  endfunction

  function automatic out_t sample();
    return {bus.pc_en, bus.IR1_en, bus.IR2_en, bus.IR3_en, bus.IR4_en,
            bus.IR1_flush, bus.IR2_flush, bus.IR3_flush, bus.IR4_flush,
            bus.pc_sel, bus.dmem_req, bus.mem_err, bus.forwardA, bus.forwardB};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    bus.rs1_IR1      = v.rs1_1;
    bus.rs2_IR1      = v.rs2_1;
    bus.rs1_IR2      = v.rs1_2;
    bus.rs2_IR2      = v.rs2_2;
    bus.instb_IR2    = v.instb2;
    bus.MemRead_IR2  = v.memread2;
    bus.instb_IR3    = v.instb3;
    bus.RegWrite_IR3 = v.regwrite3;
    bus.MemRead_IR3  = v.memread3;
    bus.MemWrite_IR3 = v.memwrite3;
    bus.Branch_IR3   = v.branch3;
    bus.zero_IR3     = v.zero3;
    bus.instb_IR4    = v.instb4;
    bus.RegWrite_IR4 = v.regwrite4;
    bus.dmem_ready   = v.ready;
  endtask

  task automatic score();
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      check(e.name, 32'(sample()), 32'(e.exp));
    end
  endtask

  // One pipeline cycle: drive after the edge, score at the following negedge.
  task automatic step(input string name, input in_t v, input out_t exp);
    @(posedge clk);
    #1;
    drive(v);
    sb_q.push_back('{name, exp});
    @(negedge clk);
    score();
  endtask

  task automatic add(input string n, input in_t i, input out_t e);
    vecs.push_back('{n, i, e});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    drive('0);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    in_t  zero, mw, s;
    out_t idle, hold_o;
    zero   = '0;
    idle   = mk(5'b11111, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    hold_o = mk(5'b00001, 4'b0001, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);

    add("idle",          zero, idle);
    add("lu_rs1",        '{default: '0, memread2: 1'b1, instb2: 5'd5, rs1_1: 5'd5},
                         mk(5'b00111, 4'b0100, 0, 0, 0, 2'b00, 2'b00));
    add("lu_rs2",        '{default: '0, memread2: 1'b1, instb2: 5'd9, rs2_1: 5'd9},
                         mk(5'b00111, 4'b0100, 0, 0, 0, 2'b00, 2'b00));
    add("lu_x0",         '{default: '0, memread2: 1'b1, instb2: 5'd0, rs1_1: 5'd0}, idle);
    add("lu_not_load",   '{default: '0, memread2: 1'b0, instb2: 5'd5, rs1_1: 5'd5}, idle);
    add("br_taken",      '{default: '0, branch3: 1'b1, zero3: 1'b1},
                         mk(5'b11111, 4'b1110, 1, 0, 0, 2'b00, 2'b00));
    add("br_not_taken",  '{default: '0, branch3: 1'b1, zero3: 1'b0}, idle);
    add("br_over_lu",    '{default: '0, branch3: 1'b1, zero3: 1'b1, memread2: 1'b1,
                           instb2: 5'd5, rs1_1: 5'd5},
                         mk(5'b11111, 4'b1110, 1, 0, 0, 2'b00, 2'b00));
    add("mem_ready",     '{default: '0, memread3: 1'b1, ready: 1'b1},
                         mk(5'b11111, 4'b0000, 0, 1, 0, 2'b00, 2'b00));
    add("st_ready_lu",   '{default: '0, memwrite3: 1'b1, ready: 1'b1, memread2: 1'b1,
                           instb2: 5'd6, rs2_1: 5'd6},
                         mk(5'b00111, 4'b0100, 0, 1, 0, 2'b00, 2'b00));
    add("fwd_mem_prio",  '{default: '0, instb3: 5'd7, instb4: 5'd7, regwrite3: 1'b1,
                           regwrite4: 1'b1, rs1_2: 5'd7},
                         mk(5'b11111, 4'b0000, 0, 0, 0, 2'b10, 2'b00));
    add("fwd_wb",        '{default: '0, instb3: 5'd7, instb4: 5'd7, regwrite3: 1'b0,
                           regwrite4: 1'b1, rs1_2: 5'd7},
                         mk(5'b11111, 4'b0000, 0, 0, 0, 2'b01, 2'b00));
    add("fwd_rs1_x0",    '{default: '0, instb3: 5'd7, instb4: 5'd7, regwrite3: 1'b1,
                           regwrite4: 1'b1, rs1_2: 5'd0}, idle);
    add("fwd_a_wb_b_mem", '{default: '0, rs1_2: 5'd4, rs2_2: 5'd3, instb3: 5'd3,
                            regwrite3: 1'b1, instb4: 5'd4, regwrite4: 1'b1},
                         mk(5'b11111, 4'b0000, 0, 0, 0, 2'b01, 2'b10));
    add("fwd_dst_x0",    '{default: '0, regwrite3: 1'b1, regwrite4: 1'b1}, idle);
    add("fwd_mem_miss",  '{default: '0, instb3: 5'd8, regwrite3: 1'b1, rs1_2: 5'd9,
                           instb4: 5'd9, regwrite4: 1'b1},
                         mk(5'b11111, 4'b0000, 0, 0, 0, 2'b01, 2'b00));
    add("fwd_wb_off",    '{default: '0, instb4: 5'd9, regwrite4: 1'b0, rs2_2: 5'd9}, idle);

    // Reset state while reset is still asserted.
    drive(zero);
    step("reset_state", zero, idle);
`ifdef PIPE_PERF_EN
    check("reset_stall_cnt", stall_cycles, 32'd0);
    check("reset_flush_cnt", flush_events, 32'd0);
`endif
    #1 reset_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp);

    // Memory wait: ready low for three cycles, then high.
    do_reset();
    mw = '{default: '0, memread3: 1'b1};
    for (int i = 0; i < 3; i++) step($sformatf("memwait_hold%0d", i), mw, hold_o);
    mw.ready = 1'b1;
    step("memwait_release", mw, mk(5'b11111, 4'b0000, 0, 1, 0, 2'b00, 2'b00));
`ifdef PIPE_PERF_EN
    check("memwait_stall_cnt", stall_cycles, 32'd3);
`endif
    step("memwait_back_run", zero, idle);
    step("perf_branch", '{default: '0, branch3: 1'b1, zero3: 1'b1},
         mk(5'b11111, 4'b1110, 1, 0, 0, 2'b00, 2'b00));
    step("perf_idle", zero, idle);
`ifdef PIPE_PERF_EN
    check("perf_flush_cnt", flush_events, 32'd1);
    check("perf_stall_kept", stall_cycles, 32'd3);
`endif

    // Memory hold beats load-use; bubble lands on the release cycle.
    s = '{default: '0, memread3: 1'b1, memread2: 1'b1, instb2: 5'd5, rs1_1: 5'd5};
    step("simul_hold", s, hold_o);
    s.ready = 1'b1;
    step("simul_release_lu", s, mk(5'b00111, 4'b0100, 0, 1, 0, 2'b00, 2'b00));
    step("simul_after", zero, idle);

    // Memory hold beats a taken branch; redirect happens on release.
    s = '{default: '0, memread3: 1'b1, branch3: 1'b1, zero3: 1'b1};
    step("hold_over_br", s, hold_o);
    s.ready = 1'b1;
    step("release_br", s, mk(5'b11111, 4'b1110, 1, 1, 0, 2'b00, 2'b00));

    // Reset in the middle of MEM_WAIT aborts the access.
    mw = '{default: '0, memread3: 1'b1};
    step("abort_hold0", mw, hold_o);
    step("abort_hold1", mw, hold_o);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    drive(zero);
    sb_q.push_back('{"abort_req_follows", idle});
    @(negedge clk);
    score();

    // Timeout: one RUN hold cycle plus four wait cycles, then ERROR.
    do_reset();
    for (int i = 0; i < 5; i++) step($sformatf("timeout_hold%0d", i), mw, hold_o);
    s = '{default: '0, memread3: 1'b1, branch3: 1'b1, zero3: 1'b1,
          rs1_2: 5'd7, instb3: 5'd7, regwrite3: 1'b1};
    step("error_state", s, mk(5'b00000, 4'b0000, 0, 0, 1, 2'b10, 2'b00));
    s.ready = 1'b1;
    step("error_sticky", s, mk(5'b00000, 4'b0000, 0, 0, 1, 2'b10, 2'b00));
    step("error_sticky2", zero, mk(5'b00000, 4'b0000, 0, 0, 1, 2'b00, 2'b00));
    @(posedge clk);
    #1 reset_n = 1'b0;
    drive(mw);
    sb_q.push_back('{"error_reset_clears", hold_o});
    @(negedge clk);
    score();
    #1 drive(zero);
    reset_n = 1'b1;
    step("error_after_reset", zero, idle);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
